// File: rtl/card_shuffle_gen_pkg.sv
// Shared types and helpers for the Card-Flip deck generator.
package card_pkg;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    SHUFFLE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Index width needed to address n slots (never less than one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Value placed in slot k before shuffling: 0,0,1,1,2,2,...
  function automatic int pair_val(input int k);
    return k >> 1;
  endfunction

endpackage

// File: rtl/card_shuffle_gen_lfsr.sv
// Free-running Galois LFSR with optional synchronous load.
// A zero seed or zero load value is replaced by 1 so the register never locks up.
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  // Load takes priority; otherwise shift right and fold in the taps when bit 0 falls out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= SEED_NZ;
    end else if (load) begin
      q <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else begin
      q <= q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);
    end
  end

endmodule

// File: rtl/card_shuffle_gen.sv
// Card-Flip deck generator: Fisher-Yates shuffle of NUM_PAIRS pairs driven by an LFSR.
// Optional macro CARD_SHUFFLE_SEED_EN adds seed_load/seed_in for reproducible decks.
//
// Handshake: start is a level request and a shuffle begins on its rising edge
// seen in IDLE or DONE (edges while busy are dropped). busy is high from the
// cycle after that edge until completion; deck is valid only while done is high
// and stays frozen there until the next rising edge of start.
module card_shuffle_gen
  import card_pkg::*;
#(
  parameter int                NUM_PAIRS = 8,
  parameter int                VAL_W     = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                RETRY_MAX = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
`ifdef CARD_SHUFFLE_SEED_EN
  input  logic                           seed_load,
  input  logic [LFSR_W-1:0]              seed_in,
`endif
  output logic [0:2*NUM_PAIRS*VAL_W-1]   deck,
  output logic                           done,
  output logic                           busy,
  output state_t                         state_o
);

  localparam int NUM_CARDS = 2 * NUM_PAIRS;
  localparam int IDX_W     = idx_w(NUM_CARDS);
  localparam int RTY_W     = idx_w(RETRY_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARDS - 1);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);

  state_t             state_q, state_d;
  logic               start_q;
  logic               start_edge;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [VAL_W-1:0]   deck_q [NUM_CARDS];
  logic [VAL_W-1:0]   deck_d [NUM_CARDS];
  logic [LFSR_W-1:0]  lfsr_q;
  logic [LFSR_W-1:0]  unused_lfsr;
  logic [IDX_W-1:0]   j;
  logic               lfsr_load;
  logic [LFSR_W-1:0]  lfsr_load_val;

`ifdef CARD_SHUFFLE_SEED_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = seed_in;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = '0;
`endif

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(LFSR_TAPS_16)),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr_q)
  );

  // Only the low bits form the candidate index; the rest feed the LFSR only.
  assign unused_lfsr = lfsr_q;
  assign j           = lfsr_q[IDX_W-1:0];
  assign start_edge  = start & ~start_q;

  // Next-state logic: initial fill, one draw per cycle, rejection with bounded retries.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rty_d   = rty_q;
    deck_d  = deck_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) state_d = INIT;
      end
      INIT: begin
        for (int k = 0; k < NUM_CARDS; k++) deck_d[k] = VAL_W'(pair_val(k));
        i_d     = LAST_IDX;
        rty_d   = '0;
        state_d = SHUFFLE;
      end
      SHUFFLE: begin
        if (i_q == '0) begin
          state_d = DONE;
        end else if (j <= i_q) begin
          deck_d[i_q] = deck_q[j];
          deck_d[j]   = deck_q[i_q];
          i_d         = i_q - 1'b1;
          rty_d       = '0;
        end else if (rty_q < RTY_LIM) begin
          rty_d = rty_q + 1'b1;
        end else begin
          // Too many rejects in a row: treat the draw as j = i (no swap) and move on.
          i_d   = i_q - 1'b1;
          rty_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and deck registers; start_q resets high so a held start is not an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      i_q     <= '0;
      rty_q   <= '0;
      for (int k = 0; k < NUM_CARDS; k++) deck_q[k] <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      i_q     <= i_d;
      rty_q   <= rty_d;
      for (int k = 0; k < NUM_CARDS; k++) deck_q[k] <= deck_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CARDS; k++) begin : g_pack
    assign deck[k*VAL_W +: VAL_W] = deck_q[k];
  end

  assign done    = (state_q == DONE);
  assign busy    = (state_q == INIT) || (state_q == SHUFFLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_card_shuffle_gen.sv
// Directed bench for card_shuffle_gen (default 8-pair instance plus a 2-pair instance).
module tb_card_shuffle_gen;
  import card_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [0:47] deck;
  logic        done, busy;
  state_t      st;

  logic        start_s;
  logic [0:3]  deck_s;
  logic        done_s, busy_s;
  state_t      st_s;

  always #5 clk = ~clk;

  card_shuffle_gen u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
`ifdef CARD_SHUFFLE_SEED_EN
    .seed_load (seed_load),
    .seed_in   (seed_in),
`endif
    .deck      (deck),
    .done      (done),
    .busy      (busy),
    .state_o   (st)
  );

  card_shuffle_gen #(.NUM_PAIRS(2), .VAL_W(1)) u_small (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start_s),
`ifdef CARD_SHUFFLE_SEED_EN
    .seed_load (1'b0),
    .seed_in   (16'h0000),
`endif
    .deck      (deck_s),
    .done      (done_s),
    .busy      (busy_s),
    .state_o   (st_s)
  );

  // ---------------- reference LFSR (tracks the main DUT cycle by cycle) ----------------
  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge resetn) begin
    if (!resetn)        m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'h0001 : seed_in;
    else                m_lfsr <= lstep(m_lfsr);
  end

  // Fisher-Yates with rejection, starting from the LFSR value seen at the start edge.
  task automatic model(input logic [15:0] l0, output logic [0:47] ev, output int lat);
    logic [2:0]  d [16];
    logic [2:0]  t;
    logic [15:0] l;
    int i, r, jj;
    for (int k = 0; k < 16; k++) d[k] = 3'(k / 2);
    l   = lstep(lstep(l0));
    i   = 15;
    r   = 0;
    lat = 2;
    while (i != 0) begin
      jj = int'(l[3:0]);
      if (jj <= i) begin
        t = d[i]; d[i] = d[jj]; d[jj] = t;
        i--; r = 0;
      end else if (r < 4) begin
        r++;
      end else begin
        i--; r = 0;
      end
      l = lstep(l);
      lat++;
    end
    for (int k = 0; k < 16; k++) ev[k*3 +: 3] = d[k];
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic hist_bad(input logic [0:47] v);
    int cnt [8];
    logic [2:0] s;
    logic bad;
    for (int k = 0; k < 8; k++) cnt[k] = 0;
    for (int k = 0; k < 16; k++) begin
      s = v[k*3 +: 3];
      cnt[s]++;
    end
    bad = 1'b0;
    for (int k = 0; k < 8; k++) if (cnt[k] != 2) bad = 1'b1;
    return bad;
  endfunction

  // ---------------- driver: one full round on the main DUT ----------------
  // Raises start, optionally pulses it at cycles 3 and 8 of the round, waits for done.
  task automatic run_round(input string tag, input bit pulses, output logic [0:47] got_deck);
    logic [0:47] ev;
    int lat, n;
    bit got;
    @(negedge clk);
    start = 1'b1;
    model(m_lfsr, ev, lat);
    @(posedge clk); #1;
    check({tag, "_busy_after_edge"}, 64'(busy), 64'd1);
    check({tag, "_done_after_edge"}, 64'(done), 64'd0);
    n = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      if (pulses) start = (n == 3 || n == 8);
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    check({tag, "_timeout"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_deck"}, 64'(deck), 64'(ev));
    check({tag, "_hist"}, 64'(hist_bad(deck)), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    got_deck = deck;
  endtask

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b1;
    seed_in   = s;
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [0:47] d0, d1, d2;
    bit held_ok;
    bit seen [16];
    int timeouts, bad, distinct, w;

    resetn = 1'b0; start = 1'b0; start_s = 1'b0;
    seed_load = 1'b0; seed_in = 16'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Idle after reset
    repeat (5) @(negedge clk);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_deck", 64'(deck), 64'd0);
    check("idle_state", 64'(st), 64'(IDLE));

    // First round, start held afterwards: no restart
    run_round("r1", 1'b0, d0);
    held_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (!done || busy) held_ok = 1'b0;
    end
    check("hold_no_restart", 64'(held_ok), 64'd1);
    check("hold_deck_frozen", 64'(deck), 64'(d0));

    // Second round with spurious edges while busy
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    run_round("r2_pulsed", 1'b1, d1);

    // Reset in the middle of SHUFFLE
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_state_shuffle", 64'(st), 64'(SHUFFLE));
    resetn = 1'b0; start = 1'b0;
    #1;
    check("mid_rst_deck", 64'(deck), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_round("r3_after_rst", 1'b0, d1);

    // start held high through reset release must not trigger a round
    @(negedge clk); start = 1'b1; resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("held_rst_busy", 64'(busy), 64'd0);
    check("held_rst_state", 64'(st), 64'(IDLE));
    start = 1'b0;
    repeat (2) @(negedge clk);
    run_round("r4_after_held", 1'b0, d1);

`ifdef CARD_SHUFFLE_SEED_EN
    // Reproducible decks from a loaded seed; seed 0 behaves as seed 1
    load_seed(16'h1234);
    run_round("seed_a", 1'b0, d0);
    load_seed(16'h1234);
    run_round("seed_b", 1'b0, d1);
    check("seed_repeat", 64'(d1), 64'(d0));
    load_seed(16'h0000);
    run_round("seed_zero", 1'b0, d1);
    load_seed(16'h0001);
    run_round("seed_one", 1'b0, d2);
    check("seed_zero_is_one", 64'(d1), 64'(d2));
`endif

    // Small 2-pair instance: 200 rounds, random gaps, all 6 arrangements expected
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 16; k++) seen[k] = 1'b0;
    timeouts = 0; bad = 0;
    for (int r = 0; r < 200; r++) begin
      start_s = 1'b0;
      repeat ($urandom_range(1, 25)) @(negedge clk);
      start_s = 1'b1;
      @(posedge clk); #1;
      w = 0;
      while (w < 100 && !done_s) begin
        @(posedge clk); #1;
        w++;
      end
      if (!done_s) timeouts++;
      else begin
        if ($countones(deck_s) != 2) bad++;
        seen[deck_s] = 1'b1;
      end
      @(negedge clk);
    end
    distinct = 0;
    for (int k = 0; k < 16; k++) if (seen[k]) distinct++;
    check("small_timeouts", 64'(timeouts), 64'd0);
    check("small_hist", 64'(bad), 64'd0);
    check("small_arrangements", 64'(distinct), 64'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
